pim_bus_responder: RTL and testbench

//  Bus-side responder for the PIM macro cluster; the slave end of the PIM DMA port.
//  - Decodes the memory-mapped PIM region.
//  - Serves the status word polled by the DMA.
//  - Buffers weight/activation/key/vref writes in a command FIFO toward the PIM core.
//  - Launches compute after a full activation vector has been handed to the core.
//  - Buffers core results in a result FIFO; PIM_R reads drain it.

---
 rtl/pim_bus_responder.sv | 196 +++++++++++++++++++
 tb/tb_pim_bus_responder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_bus_responder.sv
// pim_bus_responder
//   Slave end of the PIM DMA port. Decodes the memory-mapped PIM region,
//   serves the status word, queues weight/activation/key/vref writes toward
//   the PIM core, launches compute after a full activation vector has been
//   handed over, and buffers core results for PIM_R reads.
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_addr/i_write/i_read bus request; i_addr[3:0] is the sel_pim mask
//   i_size                byte enables, only 4'b1111 accepted for data writes
//   i_wr_data, o_rd_data  write data / registered read data (1-cycle latency)
//   o_cmd_*, i_cmd_ready  command FIFO head toward the core (pop on valid&ready)
//   o_compute_start       one-cycle compute launch pulse
//   i_core_busy           core not idle (reported in status bit 0)
//   i_res_valid/i_res_data core result push
//   o_mode                local mode register
module pim_bus_responder #(
   parameter logic [31:0] PIM_CTRL         = 32'h4000_0010,
   parameter logic [31:0] PIM_R            = 32'h4000_0020,
   parameter logic [31:0] PIM_W_WEIGHT     = 32'h4000_0040,
   parameter logic [31:0] PIM_W_ACTIVATION = 32'h4000_0080,
   parameter logic [31:0] PIM_W_KEY        = 32'h4000_0100,
   parameter logic [31:0] PIM_W_VREF       = 32'h4000_0200,
   parameter logic [31:0] PIM_W_MODE       = 32'h4000_0400,
   parameter int          CMD_DEPTH        = 8,
   parameter int          RES_DEPTH        = 16,
   parameter int          ACT_WORDS        = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_addr,
   input  logic        i_write,
   input  logic        i_read,
   input  logic [3:0]  i_size,
   input  logic [31:0] i_wr_data,
   output logic [31:0] o_rd_data,
   output logic        o_cmd_valid,
   input  logic        i_cmd_ready,
   output logic [2:0]  o_cmd_type,
   output logic [3:0]  o_cmd_sel,
   output logic [31:0] o_cmd_data,
   output logic        o_compute_start,
   input  logic        i_core_busy,
   input  logic        i_res_valid,
   input  logic [31:0] i_res_data,
   output logic [31:0] o_mode
);
   localparam int CMD_AW = $clog2(CMD_DEPTH);
   localparam int CMD_CW = CMD_AW + 1;
   localparam int RES_AW = $clog2(RES_DEPTH);
   localparam int RES_CW = RES_AW + 1;
   localparam int ACT_CW = $clog2(ACT_WORDS) + 1;
   localparam int CMD_W  = 39;   // {type[2:0], sel[3:0], data[31:0]}

   localparam logic [2:0] TYPE_WEIGHT     = 3'b001;
   localparam logic [2:0] TYPE_ACTIVATION = 3'b010;
   localparam logic [2:0] TYPE_KEY        = 3'b101;
   localparam logic [2:0] TYPE_VREF       = 3'b110;

   logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
   logic [31:0]      res_mem [RES_DEPTH];

   logic [CMD_AW-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d, cmd_rd_ptr_q, cmd_rd_ptr_d;
   logic [CMD_CW-1:0] cmd_cnt_q, cmd_cnt_d;
   logic [RES_AW-1:0] res_wr_ptr_q, res_wr_ptr_d, res_rd_ptr_q, res_rd_ptr_d;
   logic [RES_CW-1:0] res_cnt_q, res_cnt_d;
   logic [ACT_CW-1:0] act_cnt_q, act_cnt_d;
   logic              err_q, err_d, ovf_q, ovf_d, start_q, start_d;
   logic [31:0]       mode_q, mode_d, rd_data_q, rd_data_d;

   logic hit_ctrl, hit_r, hit_w, hit_a, hit_k, hit_v, hit_mode;
   logic wr_en, rd_en, data_wr, size_ok, flush, clr;
   logic cmd_full, cmd_push, cmd_pop, act_pop, act_last;
   logic res_full, res_empty, res_push, res_pop;
   logic [2:0]       wr_type;
   logic [CMD_W-1:0] cmd_head;
   logic [31:0]      status;

   assign hit_ctrl = (i_addr[31:4] == PIM_CTRL[31:4]);
   assign hit_r    = (i_addr[31:4] == PIM_R[31:4]);
   assign hit_w    = (i_addr[31:4] == PIM_W_WEIGHT[31:4]);
   assign hit_a    = (i_addr[31:4] == PIM_W_ACTIVATION[31:4]);
   assign hit_k    = (i_addr[31:4] == PIM_W_KEY[31:4]);
   assign hit_v    = (i_addr[31:4] == PIM_W_VREF[31:4]);
   assign hit_mode = (i_addr[31:4] == PIM_W_MODE[31:4]);

   // A simultaneous read and write performs neither.
   assign wr_en   = i_write & ~i_read;
   assign rd_en   = i_read & ~i_write;
   assign size_ok = (i_size == 4'b1111);
   assign data_wr = wr_en & (hit_w | hit_a | hit_k | hit_v);
   assign flush   = wr_en & hit_ctrl & i_wr_data[30];
   assign clr     = wr_en & hit_ctrl & i_wr_data[31];

   assign cmd_head  = cmd_mem[cmd_rd_ptr_q];
   assign cmd_full  = (cmd_cnt_q == CMD_CW'(CMD_DEPTH));
   assign res_full  = (res_cnt_q == RES_CW'(RES_DEPTH));
   assign res_empty = (res_cnt_q == '0);

   // Flush wins over any same-cycle push or pop.
   assign cmd_push = data_wr & size_ok & ~cmd_full & ~flush;
   assign cmd_pop  = o_cmd_valid & i_cmd_ready & ~flush;
   assign res_pop  = rd_en & hit_r & ~res_empty;
   assign res_push = i_res_valid & (~res_full | res_pop) & ~flush;

   assign act_pop  = cmd_pop & (cmd_head[38:36] == TYPE_ACTIVATION);
   assign act_last = act_pop & (act_cnt_q == ACT_CW'(ACT_WORDS - 1));

   always_comb begin
      wr_type = TYPE_WEIGHT;
      if (hit_a)      wr_type = TYPE_ACTIVATION;
      else if (hit_k) wr_type = TYPE_KEY;
      else if (hit_v) wr_type = TYPE_VREF;
   end

   always_comb begin
      status        = '0;
      status[31:16] = {{(16 - RES_CW){1'b0}}, res_cnt_q};
      status[3]     = err_q;
      status[2]     = ovf_q;
      status[1]     = ~res_empty;
      status[0]     = o_cmd_valid | i_core_busy | start_q;
   end

   always_comb begin
      cmd_wr_ptr_d = flush ? '0 : cmd_wr_ptr_q + CMD_AW'(cmd_push);
      cmd_rd_ptr_d = flush ? '0 : cmd_rd_ptr_q + CMD_AW'(cmd_pop);
      cmd_cnt_d    = flush ? '0 : cmd_cnt_q + CMD_CW'(cmd_push) - CMD_CW'(cmd_pop);
      res_wr_ptr_d = flush ? '0 : res_wr_ptr_q + RES_AW'(res_push);
      res_rd_ptr_d = flush ? '0 : res_rd_ptr_q + RES_AW'(res_pop);
      res_cnt_d    = flush ? '0 : res_cnt_q + RES_CW'(res_push) - RES_CW'(res_pop);

      act_cnt_d = act_cnt_q;
      if (flush || act_last) act_cnt_d = '0;
      else if (act_pop)      act_cnt_d = act_cnt_q + 1'b1;
      start_d = act_last;

      err_d = (err_q & ~clr)
            | (i_read & i_write)
            | (data_wr & (~size_ok | cmd_full))
            | (rd_en & hit_r & res_empty);
      ovf_d = (ovf_q & ~clr) | (i_res_valid & res_full & ~res_pop & ~flush);

      mode_d = (wr_en & hit_mode) ? i_wr_data : mode_q;

      rd_data_d = rd_data_q;
      if (rd_en) begin
         if (hit_ctrl)   rd_data_d = status;
         else if (hit_r) rd_data_d = res_empty ? 32'h0 : res_mem[res_rd_ptr_q];
         else            rd_data_d = 32'h0;
      end
   end

   // Storage arrays carry no reset; pointers and counts define validity.
   always_ff @(posedge i_clk) begin
      if (cmd_push) cmd_mem[cmd_wr_ptr_q] <= {wr_type, i_addr[3:0], i_wr_data};
      if (res_push) res_mem[res_wr_ptr_q] <= i_res_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cmd_wr_ptr_q <= '0;
         cmd_rd_ptr_q <= '0;
         cmd_cnt_q    <= '0;
         res_wr_ptr_q <= '0;
         res_rd_ptr_q <= '0;
         res_cnt_q    <= '0;
         act_cnt_q    <= '0;
         err_q        <= 1'b0;
         ovf_q        <= 1'b0;
         start_q      <= 1'b0;
         mode_q       <= '0;
         rd_data_q    <= '0;
      end else begin
         cmd_wr_ptr_q <= cmd_wr_ptr_d;
         cmd_rd_ptr_q <= cmd_rd_ptr_d;
         cmd_cnt_q    <= cmd_cnt_d;
         res_wr_ptr_q <= res_wr_ptr_d;
         res_rd_ptr_q <= res_rd_ptr_d;
         res_cnt_q    <= res_cnt_d;
         act_cnt_q    <= act_cnt_d;
         err_q        <= err_d;
         ovf_q        <= ovf_d;
         start_q      <= start_d;
         mode_q       <= mode_d;
         rd_data_q    <= rd_data_d;
      end
   end

   assign o_cmd_valid     = (cmd_cnt_q != '0);
   assign o_cmd_type      = cmd_head[38:36];
   assign o_cmd_sel       = cmd_head[35:32];
   assign o_cmd_data      = cmd_head[31:0];
   assign o_compute_start = start_q;
   assign o_mode          = mode_q;
   assign o_rd_data       = rd_data_q;
endmodule

// File: tb/tb_pim_bus_responder.sv
// Bench for pim_bus_responder: directed scenarios followed by random bus,
// core and result traffic, all compared each cycle against a queue-based
// reference model of the responder.
module tb_pim_bus_responder;
   localparam logic [31:0] A_CTRL = 32'h4000_0010;
   localparam logic [31:0] A_R    = 32'h4000_0020;
   localparam logic [31:0] A_W    = 32'h4000_0040;
   localparam logic [31:0] A_ACT  = 32'h4000_0080;
   localparam logic [31:0] A_KEY  = 32'h4000_0100;
   localparam logic [31:0] A_VREF = 32'h4000_0200;
   localparam logic [31:0] A_MODE = 32'h4000_0400;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_addr = '0;
   logic        i_write = 1'b0;
   logic        i_read = 1'b0;
   logic [3:0]  i_size = 4'hF;
   logic [31:0] i_wr_data = '0;
   logic [31:0] o_rd_data;
   logic        o_cmd_valid;
   logic        i_cmd_ready = 1'b0;
   logic [2:0]  o_cmd_type;
   logic [3:0]  o_cmd_sel;
   logic [31:0] o_cmd_data;
   logic        o_compute_start;
   logic        i_core_busy = 1'b0;
   logic        i_res_valid = 1'b0;
   logic [31:0] i_res_data = '0;
   logic [31:0] o_mode;

   int checks = 0;
   int failures = 0;
   int pulse_cnt = 0;

   // Reference model state
   logic [38:0] m_cmd[$];
   logic [31:0] m_res[$];
   bit          m_err, m_ovf, m_start;
   int          m_act;
   logic [31:0] m_mode, m_rd;

   pim_bus_responder dut (
      .i_clk(clk), .i_rst(i_rst), .i_addr(i_addr), .i_write(i_write),
      .i_read(i_read), .i_size(i_size), .i_wr_data(i_wr_data),
      .o_rd_data(o_rd_data), .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
      .o_cmd_type(o_cmd_type), .o_cmd_sel(o_cmd_sel), .o_cmd_data(o_cmd_data),
      .o_compute_start(o_compute_start), .i_core_busy(i_core_busy),
      .i_res_valid(i_res_valid), .i_res_data(i_res_data), .o_mode(o_mode)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // 0 unmapped, 1 ctrl, 2 result, 3 weight, 4 act, 5 key, 6 vref, 7 mode
   function automatic int region(input logic [31:0] a);
      case (a[31:4])
         28'h400_0001: return 1;
         28'h400_0002: return 2;
         28'h400_0004: return 3;
         28'h400_0008: return 4;
         28'h400_0010: return 5;
         28'h400_0020: return 6;
         28'h400_0040: return 7;
         default:      return 0;
      endcase
   endfunction

   function automatic logic [31:0] status_word(input bit cb);
      logic [31:0] s;
      s = '0;
      s[31:16] = 16'(m_res.size());
      s[3] = m_err;
      s[2] = m_ovf;
      s[1] = (m_res.size() > 0);
      s[0] = (m_cmd.size() > 0) || cb || m_start;
      return s;
   endfunction

   task automatic compare_outputs();
      logic [38:0] hd;
      check_value("rd_data", o_rd_data, m_rd);
      check_value("cmd_valid", 32'(o_cmd_valid), 32'(m_cmd.size() > 0));
      if (m_cmd.size() > 0) begin
         hd = m_cmd[0];
         check_value("cmd_type", 32'(o_cmd_type), 32'(hd[38:36]));
         check_value("cmd_sel", 32'(o_cmd_sel), 32'(hd[35:32]));
         check_value("cmd_data", o_cmd_data, hd[31:0]);
      end
      check_value("start", 32'(o_compute_start), 32'(m_start));
      check_value("mode", o_mode, m_mode);
      if (o_compute_start) pulse_cnt++;
   endtask

   // One clock cycle: drive, predict, clock, compare.
   task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] sz, input logic rdy, input logic rv,
                       input logic [31:0] rdat, input logic cb);
      int rg;
      bit wr, rd, flush, clear, res_pop, cmd_pop, push_ok, err_set, ovf_set, start_n;
      logic [31:0] rd_n;
      logic [38:0] head;
      logic [2:0]  ty;
      i_write = w; i_read = r; i_addr = a; i_wr_data = d; i_size = sz;
      i_cmd_ready = rdy; i_res_valid = rv; i_res_data = rdat; i_core_busy = cb;
      rg = region(a);
      wr = w && !r;
      rd = r && !w;
      err_set = w && r;
      ovf_set = 0;
      res_pop = 0;
      rd_n = m_rd;
      if (rd) begin
         if (rg == 1) rd_n = status_word(cb);
         else if (rg == 2) begin
            if (m_res.size() > 0) begin rd_n = m_res[0]; res_pop = 1; end
            else begin rd_n = 0; err_set = 1; end
         end else rd_n = 0;
      end
      flush = wr && rg == 1 && d[30];
      clear = wr && rg == 1 && d[31];
      cmd_pop = (m_cmd.size() > 0) && rdy;
      push_ok = 0;
      if (wr && rg >= 3 && rg <= 6) begin
         if (sz != 4'hF || m_cmd.size() == 8) err_set = 1;
         else push_ok = 1;
      end
      start_n = 0;
      @(posedge clk);
      #1;
      if (flush) begin
         m_cmd.delete();
         m_res.delete();
         m_act = 0;
      end else begin
         if (cmd_pop) begin
            head = m_cmd.pop_front();
            if (head[38:36] == 3'b010) begin
               m_act++;
               if (m_act == 8) begin m_act = 0; start_n = 1; end
            end
         end
         if (push_ok) begin
            case (rg)
               3:       ty = 3'b001;
               4:       ty = 3'b010;
               5:       ty = 3'b101;
               default: ty = 3'b110;
            endcase
            m_cmd.push_back({ty, a[3:0], d});
         end
         if (res_pop) void'(m_res.pop_front());
         if (rv) begin
            if (m_res.size() == 16) ovf_set = 1;
            else m_res.push_back(rdat);
         end
      end
      m_err = (clear ? 1'b0 : m_err) | err_set;
      m_ovf = (clear ? 1'b0 : m_ovf) | ovf_set;
      m_start = start_n;
      if (wr && rg == 7) m_mode = d;
      m_rd = rd_n;
      compare_outputs();
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
      step(1'b1, 1'b0, a, d, 4'hF, rdy, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic bus_rd(input logic [31:0] a, input logic rdy);
      step(1'b0, 1'b1, a, 32'h0, 4'hF, rdy, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, rdy, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic apply_reset();
      i_write = 0; i_read = 0; i_cmd_ready = 0; i_res_valid = 0; i_core_busy = 0;
      i_rst = 1'b1;
      #2;
      m_cmd.delete(); m_res.delete();
      m_err = 0; m_ovf = 0; m_start = 0; m_act = 0; m_mode = 0; m_rd = 0;
      compare_outputs();
      @(posedge clk);
      #1;
      i_rst = 1'b0;
   endtask

   logic [31:0] exp_words[16];
   logic [31:0] bases[9];

   initial begin
      int p0;
      int rg;
      logic [31:0] a, d;
      logic [3:0]  sz;
      logic        rdy, rv;
      int          op;

      apply_reset();
      check_value("rst_rd", o_rd_data, 32'h0);
      check_value("rst_mode", o_mode, 32'h0);

      // Single weight write becomes the FIFO head; status shows busy.
      bus_wr(32'h4000_0043, 32'hA5A5_0001, 1'b0);
      check_value("t1_valid", 32'(o_cmd_valid), 32'd1);
      check_value("t1_type", 32'(o_cmd_type), 32'd1);
      check_value("t1_sel", 32'(o_cmd_sel), 32'h3);
      check_value("t1_data", o_cmd_data, 32'hA5A5_0001);
      bus_rd(A_CTRL, 1'b0);
      check_value("t1_busy", 32'(o_rd_data[0]), 32'd1);
      idle(1'b1);
      check_value("t1_drained", 32'(o_cmd_valid), 32'd0);

      // Eight activation words launch exactly one compute.
      p0 = pulse_cnt;
      for (int i = 0; i < 8; i++) bus_wr(32'h4000_0081, 32'h100 + i, 1'b1);
      idle(1'b1);
      check_value("t2_start", 32'(o_compute_start), 32'd1);
      idle(1'b1);
      check_value("t2_start_end", 32'(o_compute_start), 32'd0);
      repeat (3) idle(1'b1);
      check_value("t2_pulses", pulse_cnt - p0, 32'd1);

      // Command FIFO overflow sets err; CTRL bit31 clears it; bit30 flushes.
      for (int i = 0; i < 9; i++) bus_wr(32'h4000_0041, 32'h200 + i, 1'b0);
      bus_rd(A_CTRL, 1'b0);
      check_value("t3_err", 32'(o_rd_data[3]), 32'd1);
      bus_wr(A_CTRL, 32'h8000_0000, 1'b0);
      bus_rd(A_CTRL, 1'b0);
      check_value("t3_err_clr", 32'(o_rd_data[3]), 32'd0);
      bus_wr(A_CTRL, 32'h4000_0000, 1'b0);
      check_value("t3_flush", 32'(o_cmd_valid), 32'd0);

      // Result FIFO fill, overflow, in-order drain.
      for (int i = 0; i < 16; i++) begin
         exp_words[i] = $urandom;
         step(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1, exp_words[i], 1'b0);
      end
      step(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      bus_rd(A_CTRL, 1'b0);
      check_value("t4_ctrl", o_rd_data, 32'h0010_0006);
      for (int i = 0; i < 16; i++) begin
         bus_rd(A_R, 1'b0);
         check_value("t4_word", o_rd_data, exp_words[i]);
      end
      bus_rd(A_CTRL, 1'b0);
      check_value("t4_empty", 32'(o_rd_data[1]), 32'd0);

      // Empty result read, then simultaneous read+write.
      bus_wr(A_CTRL, 32'h8000_0000, 1'b0);
      bus_rd(A_R, 1'b0);
      check_value("t5_rd_empty", o_rd_data, 32'h0);
      bus_rd(A_CTRL, 1'b0);
      check_value("t5_err", 32'(o_rd_data[3]), 32'd1);
      bus_wr(A_CTRL, 32'h8000_0000, 1'b0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h55, 1'b0);
      bus_rd(A_CTRL, 1'b0);
      check_value("t5_ctrl", o_rd_data, 32'h0001_0002);
      step(1'b1, 1'b1, A_MODE, 32'hDEAD_0001, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
      check_value("t5_rw_hold", o_rd_data, 32'h0001_0002);
      check_value("t5_rw_mode", o_mode, 32'h0);
      bus_rd(A_CTRL, 1'b0);
      check_value("t5_rw_err", 32'(o_rd_data[3]), 32'd1);

      // Reset with traffic in flight, partial activation vector pending.
      bus_wr(A_MODE, 32'h1234_5678, 1'b0);
      check_value("t6_mode", o_mode, 32'h1234_5678);
      for (int i = 0; i < 3; i++) bus_wr(A_ACT, 32'h300 + i, 1'b1);
      idle(1'b1);
      for (int i = 0; i < 3; i++) bus_wr(A_KEY, 32'h400 + i, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h500 + i, 1'b0);
      apply_reset();
      check_value("t6_rd", o_rd_data, 32'h0);
      check_value("t6_mode_rst", o_mode, 32'h0);
      check_value("t6_valid", 32'(o_cmd_valid), 32'd0);
      bus_rd(A_CTRL, 1'b0);
      check_value("t6_ctrl", o_rd_data, 32'h0);
      p0 = pulse_cnt;
      for (int i = 0; i < 8; i++) bus_wr(A_ACT, 32'h600 + i, 1'b1);
      repeat (3) idle(1'b1);
      check_value("t6_pulses", pulse_cnt - p0, 32'd1);

      // Random traffic against the model.
      bases = '{A_CTRL, A_R, A_W, A_ACT, A_KEY, A_VREF, A_MODE, 32'h4000_0800, 32'h0000_0030};
      for (int n = 0; n < 3000; n++) begin
         a = bases[$urandom_range(0, 8)] | 32'($urandom_range(0, 15));
         rg = region(a);
         d = $urandom;
         if (rg == 1) d[30] = ($urandom_range(0, 15) == 0);
         op = $urandom_range(0, 15);
         sz = 4'hF;
         if (op >= 5 && op <= 10 && rg >= 3 && rg <= 6 && $urandom_range(0, 9) == 0)
            sz = 4'($urandom_range(0, 14));
         rdy = 1'($urandom_range(0, 1));
         if (op >= 5 && op <= 10 && rg >= 3 && rg <= 6 && m_cmd.size() == 8) rdy = 1'b0;
         rv = ($urandom_range(0, 2) == 0);
         if (op >= 5 && op <= 10 && rg == 1) rv = 1'b0;
         step((op >= 5 && op <= 10) || op == 15, op >= 11, a, d, sz, rdy, rv,
              $urandom, ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
